// File: rtl/cam_capture_param_if.sv
// Camera byte stream in, frame-buffer write port out.
// The capture block takes the master view; the camera/buffer side takes the slave view.
interface cam_capture_param_if #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 12
);
  logic          CAM_vsync;
  logic          CAM_href;
  logic [7:0]    CAM_px_data;
  logic          DP_RAM_regW;
  logic [AW-1:0] DP_RAM_addr_in;
  logic [DW-1:0] DP_RAM_data_in;

  modport master (
    input  CAM_vsync, CAM_href, CAM_px_data,
    output DP_RAM_regW, DP_RAM_addr_in, DP_RAM_data_in
  );

  modport slave (
    output CAM_vsync, CAM_href, CAM_px_data,
    input  DP_RAM_regW, DP_RAM_addr_in, DP_RAM_data_in
  );
endinterface

// File: rtl/cam_capture_param.sv
// RGB565 camera capture with DEC_X x DEC_Y decimation into a linear frame buffer,
// with single-shot/continuous framing, frame counting and sticky error flags.
module cam_capture_param #(
  parameter int unsigned AW    = 15,
  parameter int unsigned DW    = 12,
  parameter int unsigned SRC_X = 640,
  parameter int unsigned SRC_Y = 480,
  parameter int unsigned DEC_X = 4,
  parameter int unsigned DEC_Y = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cam_capture_param_if.master  bus,
  input  logic                 single,
  input  logic                 arm,
  output logic                 busy,
  output logic                 frame_done,
  output logic [7:0]           frame_count,
  output logic                 line_err,
  output logic                 overflow
);

  localparam int unsigned SCREEN_X = SRC_X / DEC_X;
  localparam int unsigned SCREEN_Y = SRC_Y / DEC_Y;
  localparam int unsigned PIX      = SCREEN_X * SCREEN_Y;
  localparam int unsigned CW       = $clog2(SRC_X + 1);
  localparam int unsigned RW       = $clog2(SRC_Y + 1);
  localparam int unsigned XW       = (DEC_X > 1) ? $clog2(DEC_X) : 1;
  localparam int unsigned YW       = (DEC_Y > 1) ? $clog2(DEC_Y) : 1;
  localparam int unsigned AW1      = AW + 1;

  localparam logic [CW-1:0]  COL_LIM  = CW'(SRC_X);
  localparam logic [RW-1:0]  ROW_LIM  = RW'(SRC_Y);
  localparam logic [XW-1:0]  XMOD_MAX = XW'(DEC_X - 1);
  localparam logic [YW-1:0]  YMOD_MAX = YW'(DEC_Y - 1);
  localparam logic [AW1-1:0] PIX_A    = AW1'(PIX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VS_HI,
    S_WAIT_VS_LO,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_start;
  logic   w_end;
  logic   w_cap;

  logic           r_phase;
  logic           r_href_d;
  logic [7:0]     r_hi;
  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic [XW-1:0]  r_col_mod;
  logic [YW-1:0]  r_row_mod;
  logic [AW1-1:0] r_addr;

  logic           r_regw;
  logic [AW-1:0]  r_addr_out;
  logic [DW-1:0]  r_data_out;
  logic           r_busy;
  logic           r_frame_done;
  logic [7:0]     r_frame_count;
  logic           r_line_err;
  logic           r_overflow;

  logic           w_byte_ev;
  logic           w_line_end;
  logic           w_keep;
  logic           w_room;
  logic [15:0]    w_pix565;
  logic [DW-1:0]  w_pix_conv;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and per-cycle frame strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    w_cap       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!single || arm) w_state_nxt = S_WAIT_VS_HI;
      end
      S_WAIT_VS_HI: begin
        if (bus.CAM_vsync) w_state_nxt = S_WAIT_VS_LO;
      end
      S_WAIT_VS_LO: begin
        if (!bus.CAM_vsync) begin
          w_state_nxt = S_CAPTURE;
          w_start     = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (bus.CAM_vsync) begin
          w_state_nxt = S_DONE;
          w_end       = 1'b1;
        end else begin
          w_cap = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = single ? S_IDLE : S_WAIT_VS_LO;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_byte_ev  = w_cap && bus.CAM_href;
  assign w_line_end = w_cap && !bus.CAM_href && r_href_d;
  assign w_keep     = (r_col_mod == '0) && (r_row_mod == '0) &&
                      (r_col < COL_LIM) && (r_row < ROW_LIM);
  assign w_room     = (r_addr != PIX_A);
  assign w_pix565   = {r_hi, bus.CAM_px_data};

  // Colour reduction: keep the MSBs of each RGB565 channel
  if (DW == 8) begin : g_rgb332
    logic w_unused_bits;
    assign w_pix_conv    = {w_pix565[15:13], w_pix565[10:8], w_pix565[4:3]};
    assign w_unused_bits = ^{w_pix565[12:11], w_pix565[7:5], w_pix565[2:0]};
  end else if (DW == 12) begin : g_rgb444
    logic w_unused_bits;
    assign w_pix_conv    = {w_pix565[15:12], w_pix565[10:7], w_pix565[4:1]};
    assign w_unused_bits = ^{w_pix565[11], w_pix565[6:5], w_pix565[0]};
  end else begin : g_rgb565
    assign w_pix_conv = DW'(w_pix565);
  end

  // Byte assembly, decimation counters, buffer writes and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase       <= 1'b0;
      r_href_d      <= 1'b0;
      r_hi          <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_col_mod     <= '0;
      r_row_mod     <= '0;
      r_addr        <= '0;
      r_regw        <= 1'b0;
      r_addr_out    <= '0;
      r_data_out    <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_line_err    <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_regw       <= 1'b0;
      r_frame_done <= w_end;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_href_d     <= w_byte_ev;

      if (w_start) begin
        r_phase    <= 1'b0;
        r_col      <= '0;
        r_row      <= '0;
        r_col_mod  <= '0;
        r_row_mod  <= '0;
        r_addr     <= '0;
        r_line_err <= 1'b0;
        r_overflow <= 1'b0;
      end

      if (w_byte_ev) begin
        r_phase <= ~r_phase;
        if (!r_phase) begin
          r_hi <= bus.CAM_px_data;
        end else begin
          if (r_col != COL_LIM) r_col <= r_col + CW'(1);
          r_col_mod <= (r_col_mod == '0) ? XMOD_MAX : r_col_mod - XW'(1);
          if (w_keep) begin
            if (w_room) begin
              r_regw     <= 1'b1;
              r_addr_out <= r_addr[AW-1:0];
              r_data_out <= w_pix_conv;
              r_addr     <= r_addr + AW1'(1);
            end else begin
              r_overflow <= 1'b1;
            end
          end
        end
      end

      // Line end drops any half-assembled pixel
      if (w_line_end) begin
        if (r_row != ROW_LIM) r_row <= r_row + RW'(1);
        r_row_mod <= (r_row_mod == '0) ? YMOD_MAX : r_row_mod - YW'(1);
        r_col     <= '0;
        r_col_mod <= '0;
        r_phase   <= 1'b0;
        if (r_phase) r_line_err <= 1'b1;
      end

      if (w_end && r_phase) r_line_err <= 1'b1;

      if (r_state == S_DONE) r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign bus.DP_RAM_regW    = r_regw;
  assign bus.DP_RAM_addr_in = r_addr_out;
  assign bus.DP_RAM_data_in = r_data_out;
  assign busy               = r_busy;
  assign frame_done         = r_frame_done;
  assign frame_count        = r_frame_count;
  assign line_err           = r_line_err;
  assign overflow           = r_overflow;

endmodule

// File: tb/tb_cam_capture_param.sv
// Directed bench for cam_capture_param: two instances (RGB332 2x2 decimation and
// RGB444 4x1 decimation on a 9-wide source) fed from the same camera stream.
module tb_cam_capture_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync;
  logic       href;
  logic [7:0] pxd;
  logic       single;
  logic       arm;

  logic       busy_a, fd_a, le_a, ov_a;
  logic [7:0] fc_a;
  logic       busy_b, fd_b, le_b, ov_b;
  logic [7:0] fc_b;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  int wr_a = 0, bad_a = 0, last_a = 0, fdn_a = 0, zcyc_a = 0, exp_a = 0;
  int wr_b = 0, bad_b = 0, last_b = 0, fdn_b = 0, zcyc_b = 0, exp_b = 0;
  int s_wa, s_wb, s_fa, s_fb, s_ba, s_bb;
  int lat_cyc  = 0;
  bit lat_mark = 1'b0;

  cam_capture_param_if #(.AW(3), .DW(8))  ifa ();
  cam_capture_param_if #(.AW(3), .DW(12)) ifb ();

  assign ifa.CAM_vsync   = vsync;
  assign ifa.CAM_href    = href;
  assign ifa.CAM_px_data = pxd;
  assign ifb.CAM_vsync   = vsync;
  assign ifb.CAM_href    = href;
  assign ifb.CAM_px_data = pxd;

  cam_capture_param #(
    .AW(3), .DW(8), .SRC_X(8), .SRC_Y(4), .DEC_X(2), .DEC_Y(2)
  ) u_dut_a (
    .clk(clk), .rst(rst), .bus(ifa.master), .single(single), .arm(arm),
    .busy(busy_a), .frame_done(fd_a), .frame_count(fc_a),
    .line_err(le_a), .overflow(ov_a)
  );

  cam_capture_param #(
    .AW(3), .DW(12), .SRC_X(9), .SRC_Y(4), .DEC_X(4), .DEC_Y(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(ifb.master), .single(single), .arm(arm),
    .busy(busy_b), .frame_done(fd_b), .frame_count(fc_b),
    .line_err(le_b), .overflow(ov_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/frame_done monitor: addresses must run 0,1,2,... and data must match exp_*
  always @(negedge clk) begin
    if (ifa.DP_RAM_regW) begin
      wr_a   <= wr_a + 1;
      last_a <= int'(ifa.DP_RAM_addr_in);
      bad_a  <= bad_a
              + ((int'(ifa.DP_RAM_addr_in) != 0 && int'(ifa.DP_RAM_addr_in) != last_a + 1) ? 1 : 0)
              + ((int'(ifa.DP_RAM_data_in) != exp_a) ? 1 : 0);
      if (int'(ifa.DP_RAM_addr_in) == 0) zcyc_a <= cyc;
    end
    if (ifb.DP_RAM_regW) begin
      wr_b   <= wr_b + 1;
      last_b <= int'(ifb.DP_RAM_addr_in);
      bad_b  <= bad_b
              + ((int'(ifb.DP_RAM_addr_in) != 0 && int'(ifb.DP_RAM_addr_in) != last_b + 1) ? 1 : 0)
              + ((int'(ifb.DP_RAM_data_in) != exp_b) ? 1 : 0);
      if (int'(ifb.DP_RAM_addr_in) == 0) zcyc_b <= cyc;
    end
    if (fd_a) fdn_a <= fdn_a + 1;
    if (fd_b) fdn_b <= fdn_b + 1;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int mode, input int b);
    logic [15:0] p;
    if (mode == 0) p = 16'hF800;
    else           p = (((b / 2) % 2) == 0) ? 16'h07E0 : 16'h001F;
    return ((b % 2) == 0) ? p[15:8] : p[7:0];
  endfunction

  // Blanking, lines of 2*px bytes (line 0 optionally short / cut by vsync), blanking
  task automatic send_frame(input int lines, input int px, input int mode,
                            input int short_b, input bit vs_cut);
    vsync = 1'b1; href = 1'b0; pxd = 8'h00;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
    for (int l = 0; l < lines; l++) begin
      int nb;
      nb = (l == 0 && short_b > 0) ? short_b : 2 * px;
      for (int b = 0; b < nb; b++) begin
        href = 1'b1;
        pxd  = pat(mode, b);
        if (lat_mark && l == 0 && b == 1) lat_cyc = cyc;
        tick();
      end
      if (vs_cut && l == 0) begin
        vsync = 1'b1;
        pxd   = 8'h00;
        tick();
        break;
      end
      href = 1'b0; pxd = 8'h00;
      repeat (2) tick();
    end
    vsync = 1'b1; href = 1'b0; pxd = 8'h00;
    repeat (3) tick();
  endtask

  task automatic snap();
    s_wa = wr_a; s_wb = wr_b;
    s_fa = fdn_a; s_fb = fdn_b;
    s_ba = bad_a; s_bb = bad_b;
  endtask

  task automatic frame_checks(input string tag, input int ewa, input int ewb, input int efd);
    check_val({tag, ".A.writes"}, wr_a - s_wa, ewa);
    check_val({tag, ".B.writes"}, wr_b - s_wb, ewb);
    check_val({tag, ".A.bad_wr"}, bad_a - s_ba, 0);
    check_val({tag, ".B.bad_wr"}, bad_b - s_bb, 0);
    check_val({tag, ".A.fdone"}, fdn_a - s_fa, efd);
    check_val({tag, ".B.fdone"}, fdn_b - s_fb, efd);
    if (ewa > 0) check_val({tag, ".A.last_addr"}, last_a, ewa - 1);
    if (ewb > 0) check_val({tag, ".B.last_addr"}, last_b, ewb - 1);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, ".A.regW"},  int'(ifa.DP_RAM_regW), 0);
    check_val({tag, ".A.addr"},  int'(ifa.DP_RAM_addr_in), 0);
    check_val({tag, ".A.data"},  int'(ifa.DP_RAM_data_in), 0);
    check_val({tag, ".A.busy"},  int'(busy_a), 0);
    check_val({tag, ".A.fdone"}, int'(fd_a), 0);
    check_val({tag, ".A.fcnt"},  int'(fc_a), 0);
    check_val({tag, ".A.lerr"},  int'(le_a), 0);
    check_val({tag, ".A.ovf"},   int'(ov_a), 0);
    check_val({tag, ".B.regW"},  int'(ifb.DP_RAM_regW), 0);
    check_val({tag, ".B.addr"},  int'(ifb.DP_RAM_addr_in), 0);
    check_val({tag, ".B.data"},  int'(ifb.DP_RAM_data_in), 0);
    check_val({tag, ".B.busy"},  int'(busy_b), 0);
    check_val({tag, ".B.fcnt"},  int'(fc_b), 0);
    check_val({tag, ".B.lerr"},  int'(le_b), 0);
    check_val({tag, ".B.ovf"},   int'(ov_b), 0);
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; pxd = 8'h00; single = 1'b0; arm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("RST");
    rst = 1'b0;
    tick();

    // Solid red, continuous: 0xF800 -> RGB332 0xE0, RGB444 0xF00
    exp_a = 'hE0; exp_b = 'hF00;
    snap();
    lat_mark = 1'b1;
    send_frame(4, 8, 0, 0, 1'b0);
    lat_mark = 1'b0;
    frame_checks("T1", 8, 8, 1);
    check_val("T1.A.latency", zcyc_a, lat_cyc + 1);
    check_val("T1.B.latency", zcyc_b, lat_cyc + 1);
    check_val("T1.A.fcnt", int'(fc_a), 1);
    check_val("T1.B.fcnt", int'(fc_b), 1);
    check_val("T1.A.lerr", int'(le_a), 0);
    check_val("T1.A.ovf",  int'(ov_a), 0);
    check_val("T1.B.ovf",  int'(ov_b), 0);
    check_val("T1.A.busy", int'(busy_a), 1);

    // Line 0 only 3 bytes: one pixel kept, partial dropped, later lines realigned
    snap();
    send_frame(4, 8, 0, 3, 1'b0);
    frame_checks("T3", 5, 7, 1);
    check_val("T3.A.lerr", int'(le_a), 1);
    check_val("T3.B.lerr", int'(le_b), 1);
    check_val("T3.A.fcnt", int'(fc_a), 2);

    // Green/blue column pattern; line_err clears at frame start
    exp_a = 'h1C; exp_b = 'h0F0;
    snap();
    send_frame(4, 8, 1, 0, 1'b0);
    frame_checks("T2", 8, 8, 1);
    check_val("T2.A.lerr", int'(le_a), 0);
    check_val("T2.B.lerr", int'(le_b), 0);
    check_val("T2.A.fcnt", int'(fc_a), 3);

    // vsync rises with href high in phase 1
    exp_a = 'hE0; exp_b = 'hF00;
    snap();
    send_frame(1, 8, 0, 3, 1'b1);
    frame_checks("T3b", 1, 1, 1);
    check_val("T3b.A.lerr", int'(le_a), 1);
    check_val("T3b.B.lerr", int'(le_b), 1);
    check_val("T3b.A.fcnt", int'(fc_a), 4);

    // Single-shot: finish the pending frame, then idle until armed
    single = 1'b1;
    send_frame(4, 8, 0, 0, 1'b0);
    check_val("T4.flush.fcnt", int'(fc_a), 5);
    check_val("T4.flush.busy", int'(busy_a), 0);
    snap();
    send_frame(4, 8, 0, 0, 1'b0);
    send_frame(4, 8, 0, 0, 1'b0);
    frame_checks("T4.idle", 0, 0, 0);
    check_val("T4.idle.busy", int'(busy_a), 0);
    check_val("T4.idle.fcnt", int'(fc_a), 5);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    check_val("T4.armed.busy", int'(busy_a), 1);
    snap();
    send_frame(4, 8, 0, 0, 1'b0);
    frame_checks("T4.shot", 8, 8, 1);
    check_val("T4.shot.fcnt", int'(fc_a), 6);
    check_val("T4.shot.busy", int'(busy_a), 0);
    snap();
    send_frame(4, 8, 0, 0, 1'b0);
    frame_checks("T4.after", 0, 0, 0);

    // Oversized frame: A clips at SRC_X/SRC_Y; B keeps 12 pixels into an 8-entry buffer
    single = 1'b0;
    snap();
    send_frame(6, 10, 0, 0, 1'b0);
    frame_checks("T5", 8, 8, 1);
    check_val("T5.A.ovf", int'(ov_a), 0);
    check_val("T5.B.ovf", int'(ov_b), 1);
    check_val("T5.A.fcnt", int'(fc_a), 7);

    // Reset during line 1, released mid-frame: no capture until a fresh vsync cycle
    fork
      send_frame(4, 8, 0, 0, 1'b0);
      begin
        repeat (28) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_zero("T6.rst");
        snap();
        tick();
        tick();
        rst = 1'b0;
      end
    join
    frame_checks("T6.rest", 0, 0, 0);
    check_val("T6.rest.fcnt", int'(fc_a), 0);
    snap();
    send_frame(4, 8, 0, 0, 1'b0);
    frame_checks("T6.next", 8, 8, 1);
    check_val("T6.next.fcnt", int'(fc_a), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
